// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_pkg : note frequencies, clock/silence defaults, volume amplitudes  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned SIL      = 100_000_000;
  localparam int unsigned MAX_TONE = 20_000;

  // Note frequencies in Hz, low octave through high octave plus the D above.
  localparam int unsigned lc   = 131;
  localparam int unsigned ld   = 147;
  localparam int unsigned le   = 165;
  localparam int unsigned lf   = 174;
  localparam int unsigned lg   = 196;
  localparam int unsigned la   = 220;
  localparam int unsigned lb   = 247;
  localparam int unsigned c    = 262;
  localparam int unsigned d    = 294;
  localparam int unsigned e    = 330;
  localparam int unsigned f    = 349;
  localparam int unsigned g    = 392;
  localparam int unsigned a    = 440;
  localparam int unsigned b    = 494;
  localparam int unsigned hc   = 524;
  localparam int unsigned hd   = 588;
  localparam int unsigned he   = 660;
  localparam int unsigned hf   = 698;
  localparam int unsigned hg   = 784;
  localparam int unsigned ha   = 880;
  localparam int unsigned hb   = 988;
  localparam int unsigned up_d = 1176;

  localparam logic [7:0][15:0] VOL_AMP = {
    16'h4000, 16'h4000, 16'h4000, 16'h2000,
    16'h1000, 16'h0800, 16'h0400, 16'h0000
  };

  function automatic logic [15:0] sample_of(input logic sq, input logic silent,
                                            input logic mute_v, input logic [15:0] amp);
    logic [15:0] s;
    if (mute_v || silent || (amp == 16'h0000)) s = 16'h0000;
    else if (sq) s = amp;
    else s = 16'h0000 - amp;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/square_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | square_gen : per-channel square wave at the requested tone frequency     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module square_gen #(
  parameter int unsigned CLK_HZ = audio_pkg::CLK_HZ,
  parameter int unsigned SIL    = audio_pkg::SIL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tone_i,
  output logic        sq_o,
  output logic        silent_o
);
  import audio_pkg::*;

  localparam logic [32:0] CLK_W = 33'(CLK_HZ);

  logic [31:0] tone_q;
  logic [26:0] cnt_q, cnt_d;
  logic        sq_q, sq_d;
  logic [32:0] div_w, limit_w;
  logic        wrap_w;

  assign silent_o = (tone_q == 32'd0) || (tone_q == 32'(SIL)) || (tone_q > 32'(MAX_TONE));
  // A zero divisor only occurs for a silent channel; keep the divider defined.
  assign div_w    = (tone_q == 32'd0) ? 33'd1 : {tone_q, 1'b0};
  assign limit_w  = CLK_W / div_w;
  assign wrap_w   = ({6'd0, cnt_q} == (limit_w - 33'd1));
  assign sq_o     = sq_q;

  always_comb begin
    cnt_d = cnt_q + 27'd1;
    sq_d  = sq_q;
    if (silent_o) begin
      cnt_d = 27'd0;
      sq_d  = 1'b0;
    end else if (wrap_w) begin
      cnt_d = 27'd0;
      sq_d  = ~sq_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_q <= 32'd0;
      cnt_q  <= 27'd0;
      sq_q   <= 1'b0;
    end else if (tone_i != tone_q) begin
      tone_q <= tone_i;
      cnt_q  <= 27'd0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tone_to_dac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_to_dac : stereo square-wave tones serialised to a left-justified DAC |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tone_to_dac #(
  parameter int unsigned CLK_HZ = audio_pkg::CLK_HZ,
  parameter int unsigned SIL    = audio_pkg::SIL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] toneL,
  input  logic [31:0] toneR,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);
  import audio_pkg::*;

  logic [8:0]  cnt_q, cnt_d;
  logic        mclk_q, sck_q, lrck_q;
  logic [31:0] shift_q, shift_d;
  logic        sq_l, sil_l, sq_r, sil_r;
  logic [15:0] amp_w, samp_l, samp_r;

  square_gen #(.CLK_HZ(CLK_HZ), .SIL(SIL)) u_sq_l (
    .clk      (clk),
    .rst      (rst),
    .tone_i   (toneL),
    .sq_o     (sq_l),
    .silent_o (sil_l)
  );

  square_gen #(.CLK_HZ(CLK_HZ), .SIL(SIL)) u_sq_r (
    .clk      (clk),
    .rst      (rst),
    .tone_i   (toneR),
    .sq_o     (sq_r),
    .silent_o (sil_r)
  );

  assign amp_w  = VOL_AMP[volume];
  assign samp_l = sample_of(sq_l, sil_l, mute, amp_w);
  assign samp_r = sample_of(sq_r, sil_r, mute, amp_w);

  // Both channels are captured on the last count of a frame so the next
  // frame starts with the left MSB while lrck is low.
  always_comb begin
    cnt_d   = cnt_q + 9'd1;
    shift_d = shift_q;
    if (cnt_q == 9'd511) shift_d = {samp_l, samp_r};
    else if (cnt_q[3:0] == 4'hF) shift_d = {shift_q[30:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 9'd0;
      mclk_q  <= 1'b0;
      sck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      mclk_q  <= cnt_d[1];
      sck_q   <= cnt_d[3];
      lrck_q  <= cnt_d[8];
      shift_q <= shift_d;
    end
  end

  assign audio_mclk = mclk_q;
  assign audio_sck  = sck_q;
  assign audio_lrck = lrck_q;
  assign audio_sdin = shift_q[31];

endmodule
`default_nettype wire

// File: tb/tb_tone_to_dac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tone_to_dac : self-checking bench with a frame scoreboard             |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_tone_to_dac;

  // 1 MHz system clock: half-periods are 1/100 of the 100 MHz figures
  // (1000 Hz -> 500, 440 Hz -> 1136, 524 Hz -> 954).
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned SIL    = audio_pkg::SIL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] toneL = 32'd0;
  logic [31:0] toneR = 32'd0;
  logic [2:0]  volume = 3'd0;
  logic        mute = 1'b0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

  int          n = 0;
  int          n_passed = 0;
  int          n_checks = 0;
  logic [31:0] sb_q[$];
  logic [31:0] toneL_m = 32'd0, toneR_m = 32'd0;
  int          chgL = 0, chgR = 0;
  logic [31:0] frame_w = 32'd0;
  logic [31:0] exp_w;
  int          pos;

  tone_to_dac #(.CLK_HZ(CLK_HZ), .SIL(SIL)) dut (
    .clk        (clk),
    .rst        (rst),
    .toneL      (toneL),
    .toneR      (toneR),
    .volume     (volume),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_sample(input logic [31:0] t, input int chg, input int at_n,
                                             input logic [2:0] v, input logic m);
    logic [15:0] amp;
    int          hp;
    bit          sq;
    case (v)
      3'd0:    amp = 16'h0000;
      3'd1:    amp = 16'h0400;
      3'd2:    amp = 16'h0800;
      3'd3:    amp = 16'h1000;
      3'd4:    amp = 16'h2000;
      default: amp = 16'h4000;
    endcase
    if (m || amp == 16'h0000 || t == 32'd0 || t == SIL || t > 32'd20000) return 16'h0000;
    hp = int'(CLK_HZ / (2 * t));
    sq = (((at_n - 1 - chg) / hp) % 2) == 1;
    return sq ? amp : 16'h0000 - amp;
  endfunction

  // Model: edge count since reset release, tone-change edges, frame snapshots.
  always @(posedge clk) begin
    if (!rst) begin
      n = 0;
      sb_q.delete();
      toneL_m = 32'd0;
      toneR_m = 32'd0;
      chgL = 0;
      chgR = 0;
    end else begin
      n = n + 1;
      if (n % 512 == 0)
        sb_q.push_back({exp_sample(toneL_m, chgL, n, volume, mute),
                        exp_sample(toneR_m, chgR, n, volume, mute)});
      if (toneL != toneL_m) begin toneL_m = toneL; chgL = n; end
      if (toneR != toneR_m) begin toneR_m = toneR; chgR = n; end
    end
  end

  // Monitor: rebuild each frame from mid-bit samples of sdin.
  always @(negedge clk) begin
    if (rst && n > 0) begin
      pos = n % 512;
      if (pos % 16 == 8) frame_w[31 - pos / 16] = audio_sdin;
      if (pos == 504 && sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        n_checks++;
        if (frame_w !== exp_w) $display("FAIL frame@%0d: got %h expected %h", n, frame_w, exp_w);
        else n_passed++;
      end
    end
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (n % 512 == v) break;
    end
  endtask

  task automatic wait_toggle(input bit right, output int at_n);
    logic prev, cur;
    prev = right ? dut.u_sq_r.sq_o : dut.u_sq_l.sq_o;
    at_n = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cur = right ? dut.u_sq_r.sq_o : dut.u_sq_l.sq_o;
      if (cur !== prev) begin at_n = n; break; end
    end
  endtask

  task automatic test_clock_timing(input string tag);
    int mr[2], sr[2], lr[2];
    int mi, si, li;
    logic pm, ps, pl;
    mr[0] = -1; mr[1] = -1; sr[0] = -1; sr[1] = -1; lr[0] = -1; lr[1] = -1;
    mi = 0; si = 0; li = 0; pm = 1'b0; ps = 1'b0; pl = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (audio_mclk && !pm && mi < 2) begin mr[mi] = n; mi++; end
      if (audio_sck  && !ps && si < 2) begin sr[si] = n; si++; end
      if (audio_lrck && !pl && li < 2) begin lr[li] = n; li++; end
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end
    n_checks++;
    if (lr[0] !== 256) $display("FAIL %s lrck_first_rise: got %0d expected 256", tag, lr[0]);
    else n_passed++;
    n_checks++;
    if (mr[1] - mr[0] !== 4) $display("FAIL %s mclk_period: got %0d expected 4", tag, mr[1] - mr[0]);
    else n_passed++;
    n_checks++;
    if (sr[1] - sr[0] !== 16) $display("FAIL %s sck_period: got %0d expected 16", tag, sr[1] - sr[0]);
    else n_passed++;
    n_checks++;
    if (lr[1] - lr[0] !== 512) $display("FAIL %s lrck_period: got %0d expected 512", tag, lr[1] - lr[0]);
    else n_passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (audio_mclk !== 1'b0) $display("FAIL reset_mclk: got %b expected 0", audio_mclk);
    else n_passed++;
    n_checks++;
    if (audio_sck !== 1'b0) $display("FAIL reset_sck: got %b expected 0", audio_sck);
    else n_passed++;
    n_checks++;
    if (audio_lrck !== 1'b0) $display("FAIL reset_lrck: got %b expected 0", audio_lrck);
    else n_passed++;
    n_checks++;
    if (audio_sdin !== 1'b0) $display("FAIL reset_sdin: got %b expected 0", audio_sdin);
    else n_passed++;
    test_clock_timing("por");
  endtask

  task automatic test_tone_1000();
    int chg, t1, t2, r1;
    toneL = 32'd1000; toneR = 32'd1000; volume = 3'd4;
    @(negedge clk);
    chg = n;
    wait_toggle(1'b0, t1);
    wait_toggle(1'b0, t2);
    n_checks++;
    if (t1 - chg !== 500) $display("FAIL t1000_first_half: got %0d expected 500", t1 - chg);
    else n_passed++;
    n_checks++;
    if (t2 - t1 !== 500) $display("FAIL t1000_half: got %0d expected 500", t2 - t1);
    else n_passed++;
    wait_toggle(1'b1, r1);
    n_checks++;
    if ((r1 - chg) % 500 !== 0 || r1 < 0) $display("FAIL t1000_right_phase: got %0d expected multiple of 500", r1 - chg);
    else n_passed++;
    repeat (2560) @(negedge clk);
  endtask

  task automatic test_tone_440();
    int chg, t1, t2, ones;
    toneL = audio_pkg::a; toneR = SIL; volume = 3'd5;
    @(negedge clk);
    chg = n;
    wait_toggle(1'b0, t1);
    wait_toggle(1'b0, t2);
    n_checks++;
    if (t1 - chg !== 1136) $display("FAIL t440_first_half: got %0d expected 1136", t1 - chg);
    else n_passed++;
    n_checks++;
    if (t2 - t1 !== 1136) $display("FAIL t440_half: got %0d expected 1136", t2 - t1);
    else n_passed++;
    n_checks++;
    if (dut.u_sq_r.silent_o !== 1'b1) $display("FAIL t440_right_silent: got %b expected 1", dut.u_sq_r.silent_o);
    else n_passed++;
    wait_cnt(0);
    ones = 0;
    for (int i = 0; i < 3 * 512; i++) begin
      if ((n % 512) % 16 == 8 && (n % 512) >= 256 && audio_sdin) ones++;
      @(negedge clk);
    end
    n_checks++;
    if (ones !== 0) $display("FAIL t440_right_word: got %0d one-bits expected 0", ones);
    else n_passed++;
  endtask

  task automatic test_mute_vol0();
    int ones;
    toneL = audio_pkg::c; toneR = audio_pkg::c; volume = 3'd4; mute = 1'b1;
    wait_cnt(0);
    ones = 0;
    for (int i = 0; i < 3 * 512; i++) begin
      @(negedge clk);
      if (audio_sdin) ones++;
    end
    n_checks++;
    if (ones !== 0) $display("FAIL mute_sdin: got %0d high cycles expected 0", ones);
    else n_passed++;
    mute = 1'b0; volume = 3'd0;
    wait_cnt(0);
    ones = 0;
    for (int i = 0; i < 3 * 512; i++) begin
      @(negedge clk);
      if (audio_sdin) ones++;
    end
    n_checks++;
    if (ones !== 0) $display("FAIL vol0_sdin: got %0d high cycles expected 0", ones);
    else n_passed++;
  endtask

  task automatic test_tone_change();
    int chg, t1, t2;
    volume = 3'd4;
    wait_cnt(0);
    wait_cnt(100);
    toneL = audio_pkg::hc;
    @(negedge clk);
    chg = n;
    n_checks++;
    if (dut.u_sq_l.cnt_q !== 27'd0 || dut.u_sq_l.sq_o !== 1'b0)
      $display("FAIL change_restart: got cnt %0d sq %b expected cnt 0 sq 0", dut.u_sq_l.cnt_q, dut.u_sq_l.sq_o);
    else n_passed++;
    wait_toggle(1'b0, t1);
    wait_toggle(1'b0, t2);
    n_checks++;
    if (t1 - chg !== 954) $display("FAIL change_first_half: got %0d expected 954", t1 - chg);
    else n_passed++;
    n_checks++;
    if (t2 - t1 !== 954) $display("FAIL change_half: got %0d expected 954", t2 - t1);
    else n_passed++;
    repeat (1024) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    wait_cnt(300);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({audio_mclk, audio_sck, audio_lrck, audio_sdin} !== 4'b0000)
      $display("FAIL midreset_outputs: got %b expected 0000", {audio_mclk, audio_sck, audio_lrck, audio_sdin});
    else n_passed++;
    repeat (3) @(negedge clk);
    test_clock_timing("mid");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tone_1000();
    test_tone_440();
    test_mute_vol0();
    test_tone_change();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
